multicycle_control: RTL and testbench

Main sequencing FSM for the multicycle RISC-V core. It steps each instruction through fetch, decode, execute, memory and write-back. It drives the datapath enables and mux selects, and generates the 2-bit ALUOp consumed by the ALU control decoder. Supported opcodes are R-type, LW, SW and BEQ. It also handles memory wait states and run/stop at instruction boundaries, and keeps a retired-instruction counter.

---
 rtl/multicycle_control.sv | 247 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main sequencing FSM for the multicycle RISC-V core. Each instruction is
// stepped through fetch, decode, execute, memory and write-back. The block
// drives the datapath enables and mux selects, produces the 2-bit ALUOp for
// the ALU control decoder, absorbs memory wait states, starts and stops only
// at instruction boundaries and counts retired instructions.
//
// Supported opcodes: R-type, LW, SW, BEQ. Anything else is flagged as
// illegal in DECODE and skipped.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   run            1 = execute; sampled only in IDLE and at instruction end
//   opcode[6:0]    IR[6:0], valid from DECODE onward
//   mem_ready      memory completes the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU zero
//   pc_source      0 = ALU result, 1 = ALUOut register
//   iord           memory address: 0 = PC, 1 = ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       IR load
//   reg_write      register-file write
//   mem_to_reg     write-back source: 0 = ALUOut, 1 = MDR
//   alu_src_a      0 = PC, 1 = rs1
//   alu_src_b[1:0] 00 = rs2, 01 = constant 4, 10 = immediate
//   alu_op[1:0]    00 = add, 01 = sub, 10 = funct-decoded
//   instr_done     one-cycle pulse when an instruction retires
//   illegal        one-cycle pulse on an unsupported opcode
//   state[3:0]     current state code (debug)
//   instr_count    retired instructions, wraps modulo 2^CNT_W
//
// Memory handshake: mem_read / mem_write act as "valid" and stay asserted
// for as long as the FSM sits in FETCH, MEM_RD or MEM_WR. mem_ready is the
// "ready" side; an access completes in exactly the cycle where the request
// and mem_ready are both high, and the FSM leaves the access state on that
// clock edge. The request is never withdrawn before completion and
// mem_ready is ignored in every other state.
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             instr_done,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_R   = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    state_t cur_state;
    state_t next_state;
    logic   retire;
    logic   opcode_ok;

    assign state = cur_state;

    // Recognised opcode check, used to raise the illegal pulse in DECODE.
    always_comb begin
        opcode_ok = 1'b0;
        case (opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ: opcode_ok = 1'b1;
            default:                    opcode_ok = 1'b0;
        endcase
    end

    // An instruction retires in its last cycle. MEM_WR is the only retire
    // state that can stall, so it retires only once the write is accepted.
    always_comb begin
        retire = 1'b0;
        case (cur_state)
            S_WB_R, S_WB_MEM, S_BRANCH: retire = 1'b1;
            S_MEM_WR:                   retire = mem_ready;
            default:                    retire = 1'b0;
        endcase
    end

    // Next-state logic. run is consulted only in IDLE and at instruction
    // end (retire or illegal opcode), so dropping it mid-instruction lets
    // the current instruction finish.
    always_comb begin
        next_state = S_IDLE;
        case (cur_state)
            S_IDLE:   next_state = run ? S_FETCH : S_IDLE;
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_R:         next_state = S_EXEC_R;
                    OP_LW, OP_SW: next_state = S_ADDR;
                    OP_BEQ:       next_state = S_BRANCH;
                    default:      next_state = run ? S_FETCH : S_IDLE;
                endcase
            end
            S_EXEC_R: next_state = S_WB_R;
            S_ADDR:   next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: next_state = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: begin
                if (mem_ready) begin
                    next_state = run ? S_FETCH : S_IDLE;
                end else begin
                    next_state = S_MEM_WR;
                end
            end
            S_WB_R, S_WB_MEM, S_BRANCH: next_state = run ? S_FETCH : S_IDLE;
            // Codes 10-15 are not reachable; recover to IDLE if one appears.
            default:  next_state = S_IDLE;
        endcase
    end

    // State register and retired-instruction counter. The counter wraps
    // naturally from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= S_IDLE;
            instr_count <= '0;
        end else begin
            cur_state <= next_state;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Output decode. Everything is a function of the current state except
    // the FETCH IR/PC loads, which wait for the instruction word to arrive,
    // and the MEM_WR retire pulse. Because all outputs derive from the
    // state register, asserting rst_n drives them all to 0 immediately.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_ADD;
        illegal       = 1'b0;
        instr_done    = retire;

        case (cur_state)
            S_FETCH: begin
                // PC + 4 is computed in the same cycle as the fetch.
                mem_read  = 1'b1;
                iord      = 1'b0;
                alu_src_a = 1'b0;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_ADD;
                pc_source = 1'b0;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target PC + imm into ALUOut.
                alu_src_a = 1'b0;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_ADD;
                illegal   = !opcode_ok;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_FUNCT;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b0;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                // rs1 - rs2 sets zero; the PC takes ALUOut only if equal.
                alu_src_a     = 1'b1;
                alu_src_b     = SRC_B_RS2;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
            end
            default: begin
                // IDLE and unreachable codes: everything stays 0.
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Bench for multicycle_control. Two instances share all inputs: one with
// the default 32-bit counter and one with a 4-bit counter for wrap checks.
// Inputs change just after the falling edge and outputs are sampled 1 ns
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       run;
    logic [6:0] opcode;
    logic       mem_ready;

    logic        pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write;
    logic        ir_write, reg_write, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        instr_done, illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;

    logic        pc_write4, pc_write_cond4, pc_source4, iord4, mem_read4, mem_write4;
    logic        ir_write4, reg_write4, mem_to_reg4, alu_src_a4;
    logic [1:0]  alu_src_b4, alu_op4;
    logic        instr_done4, illegal4;
    logic [3:0]  state4;
    logic [3:0]  instr_count4;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
        .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .pc_source(pc_source4),
        .iord(iord4), .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4),
        .reg_write(reg_write4), .mem_to_reg(mem_to_reg4), .alu_src_a(alu_src_a4),
        .alu_src_b(alu_src_b4), .alu_op(alu_op4), .instr_done(instr_done4),
        .illegal(illegal4), .state(state4), .instr_count(instr_count4)
    );

    logic [15:0] all_outs;
    assign all_outs = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
                       ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                       instr_done, illegal};

    int checks   = 0;
    int failures = 0;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; opcode = 7'd0; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle's inputs, then settle so outputs can be sampled.
    task automatic cyc(input logic r, input logic [6:0] op, input logic mr);
        @(negedge clk);
        run = r; opcode = op; mem_ready = mr;
        #1;
    endtask

    // ---------------- reference-model step record ----------------
    typedef struct packed {
        logic [3:0] st;
        logic       done;
        logic       ill;
        logic       mrd;
        logic       mwr;
        logic       mr;
        logic       rn;
        logic       ret;
        logic [6:0] op;
    } step_t;

    function automatic step_t mk(input logic [3:0] st, input logic done, input logic ill,
                                 input logic mrd, input logic mwr, input logic mr,
                                 input logic rn, input logic [6:0] op);
        step_t s;
        s.st = st; s.done = done; s.ill = ill; s.mrd = mrd; s.mwr = mwr;
        s.mr = mr; s.rn = rn; s.ret = done; s.op = op;
        return s;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; opcode = 7'd0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++;
        if (all_outs !== 16'd0) begin failures++; $display("FAIL reset_outs got=%h exp=0000", all_outs); end
        checks++;
        if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_r_type();
        do_reset();
        cyc(1'b1, OP_R, 1'b1);
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL r_idle got=%0d exp=0", state); end
        cyc(1'b1, OP_R, 1'b1);
        checks++;
        if ({state, mem_read, iord, ir_write, pc_write, alu_src_b, alu_op} !== {4'd1, 4'b1011, 2'b01, 2'b00}) begin
            failures++; $display("FAIL r_fetch got st=%0d mr=%b iord=%b irw=%b pcw=%b srcb=%b aluop=%b exp st=1 1 0 1 1 01 00",
                                 state, mem_read, iord, ir_write, pc_write, alu_src_b, alu_op);
        end
        cyc(1'b1, OP_R, 1'b1);
        checks++;
        if ({state, alu_src_a, alu_src_b, alu_op} !== {4'd2, 1'b0, 2'b10, 2'b00}) begin
            failures++; $display("FAIL r_decode got st=%0d a=%b b=%b op=%b exp st=2 0 10 00", state, alu_src_a, alu_src_b, alu_op);
        end
        cyc(1'b1, OP_R, 1'b1);
        checks++;
        if ({state, alu_src_a, alu_src_b, alu_op} !== {4'd3, 1'b1, 2'b00, 2'b10}) begin
            failures++; $display("FAIL r_exec got st=%0d a=%b b=%b op=%b exp st=3 1 00 10", state, alu_src_a, alu_src_b, alu_op);
        end
        cyc(1'b1, OP_R, 1'b1);
        checks++;
        if ({state, reg_write, mem_to_reg, instr_done} !== {4'd7, 3'b101}) begin
            failures++; $display("FAIL r_wb got st=%0d rw=%b m2r=%b done=%b exp st=7 1 0 1", state, reg_write, mem_to_reg, instr_done);
        end
        cyc(1'b1, OP_R, 1'b1);
        checks++;
        if ({state, instr_done, instr_count} !== {4'd1, 1'b0, 32'd1}) begin
            failures++; $display("FAIL r_next got st=%0d done=%b cnt=%0d exp st=1 0 1", state, instr_done, instr_count);
        end
    endtask

    task automatic test_lw_waits();
        int n_cyc;
        int done_at;
        logic [1:0] mr_pat;
        do_reset();
        cyc(1'b1, OP_LW, 1'b0);   // IDLE, run sampled
        n_cyc = 0; done_at = 0;
        // Fetch: two wait cycles, then ready.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, OP_LW, (k == 2));
            n_cyc++;
            mr_pat = {ir_write, pc_write};
            checks++;
            if (state !== 4'd1 || mr_pat !== ((k == 2) ? 2'b11 : 2'b00) || mem_read !== 1'b1) begin
                failures++; $display("FAIL lw_fetch%0d got st=%0d irw_pcw=%b mr=%b exp st=1 irw_pcw=%b mr=1",
                                     k, state, mr_pat, mem_read, (k == 2) ? 2'b11 : 2'b00);
            end
        end
        cyc(1'b1, OP_LW, 1'b0); n_cyc++;   // DECODE
        cyc(1'b1, OP_LW, 1'b0); n_cyc++;   // ADDR
        checks++;
        if (state !== 4'd4) begin failures++; $display("FAIL lw_addr got=%0d exp=4", state); end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, OP_LW, (k == 3));
            n_cyc++;
            checks++;
            if ({state, mem_read, iord, mem_write, ir_write, pc_write} !== {4'd5, 5'b11000}) begin
                failures++; $display("FAIL lw_memrd%0d got st=%0d mr=%b iord=%b mw=%b irw=%b pcw=%b exp st=5 1 1 0 0 0",
                                     k, state, mem_read, iord, mem_write, ir_write, pc_write);
            end
        end
        cyc(1'b0, OP_LW, 1'b0); n_cyc++;   // WB_MEM
        if (instr_done === 1'b1) done_at = n_cyc;
        checks++;
        if ({state, reg_write, mem_to_reg} !== {4'd8, 2'b11}) begin
            failures++; $display("FAIL lw_wb got st=%0d rw=%b m2r=%b exp st=8 1 1", state, reg_write, mem_to_reg);
        end
        checks++;
        if (done_at !== 10) begin failures++; $display("FAIL lw_latency got=%0d exp=10", done_at); end
    endtask

    task automatic test_sw_beq();
        int done_cnt;
        do_reset();
        done_cnt = 0;
        cyc(1'b1, OP_SW, 1'b1);   // IDLE
        cyc(1'b1, OP_SW, 1'b1);   // FETCH
        cyc(1'b1, OP_SW, 1'b1);   // DECODE
        cyc(1'b1, OP_SW, 1'b1);   // ADDR
        cyc(1'b1, OP_SW, 1'b1);   // MEM_WR, accepted
        checks++;
        if ({state, mem_write, iord, mem_read, instr_done} !== {4'd6, 4'b1101}) begin
            failures++; $display("FAIL sw_memwr got st=%0d mw=%b iord=%b mr=%b done=%b exp st=6 1 1 0 1",
                                 state, mem_write, iord, mem_read, instr_done);
        end
        cyc(1'b1, OP_BEQ, 1'b1);  // FETCH directly, no IDLE bubble
        checks++;
        if (state !== 4'd1) begin failures++; $display("FAIL sw_b2b got=%0d exp=1", state); end
        cyc(1'b1, OP_BEQ, 1'b1);  // DECODE
        cyc(1'b1, OP_BEQ, 1'b1);  // BRANCH
        checks++;
        if ({state, alu_op, pc_write_cond, pc_source, alu_src_a, alu_src_b, instr_done} !== {4'd9, 2'b01, 3'b111, 2'b00, 1'b1}) begin
            failures++; $display("FAIL beq_branch got st=%0d op=%b pcwc=%b pcs=%b a=%b b=%b done=%b exp st=9 01 1 1 1 00 1",
                                 state, alu_op, pc_write_cond, pc_source, alu_src_a, alu_src_b, instr_done);
        end
        cyc(1'b0, OP_BEQ, 1'b1);
        checks++;
        if (instr_count !== 32'd2) begin failures++; $display("FAIL sw_beq_count got=%0d exp=2", instr_count); end
    endtask

    task automatic test_illegal();
        do_reset();
        cyc(1'b1, 7'h7f, 1'b1);   // IDLE
        cyc(1'b1, 7'h7f, 1'b1);   // FETCH
        cyc(1'b1, 7'h7f, 1'b1);   // DECODE
        checks++;
        if ({state, illegal, instr_done} !== {4'd2, 2'b10}) begin
            failures++; $display("FAIL illegal_decode got st=%0d ill=%b done=%b exp st=2 1 0", state, illegal, instr_done);
        end
        cyc(1'b1, OP_R, 1'b0);
        checks++;
        if ({state, illegal, instr_count} !== {4'd1, 1'b0, 32'd0}) begin
            failures++; $display("FAIL illegal_after got st=%0d ill=%b cnt=%0d exp st=1 0 0", state, illegal, instr_count);
        end
    endtask

    task automatic test_run_drop();
        do_reset();
        cyc(1'b1, OP_R, 1'b1);    // IDLE
        cyc(1'b1, OP_R, 1'b1);    // FETCH
        cyc(1'b1, OP_R, 1'b1);    // DECODE
        cyc(1'b0, OP_R, 1'b1);    // EXEC_R, run dropped
        checks++;
        if (state !== 4'd3) begin failures++; $display("FAIL drop_exec got=%0d exp=3", state); end
        cyc(1'b0, OP_R, 1'b1);    // WB_R still completes
        checks++;
        if ({state, instr_done} !== {4'd7, 1'b1}) begin
            failures++; $display("FAIL drop_wb got st=%0d done=%b exp st=7 1", state, instr_done);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, OP_R, $urandom_range(0, 1));
            checks++;
            if (state !== 4'd0 || all_outs !== 16'd0) begin
                failures++; $display("FAIL drop_idle%0d got st=%0d outs=%h exp st=0 outs=0000", k, state, all_outs);
            end
        end
        cyc(1'b1, OP_R, 1'b1);    // IDLE samples run
        cyc(1'b1, OP_R, 1'b1);
        checks++;
        if (state !== 4'd1) begin failures++; $display("FAIL drop_resume got=%0d exp=1", state); end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(1'b1, OP_BEQ, 1'b1);  // IDLE
        for (int n = 0; n < 16; n++) begin
            repeat (3) cyc(1'b1, OP_BEQ, 1'b1);
            if (n == 14) begin
                cyc(1'b1, OP_BEQ, 1'b1);  // FETCH of #16, count now 15
                checks++;
                if (instr_count4 !== 4'd15) begin failures++; $display("FAIL wrap_15 got=%0d exp=15", instr_count4); end
                repeat (2) cyc(1'b1, OP_BEQ, 1'b1);
                n++;
            end
        end
        cyc(1'b0, OP_BEQ, 1'b1);
        checks++;
        if (instr_count4 !== 4'd0) begin failures++; $display("FAIL wrap_4bit got=%0d exp=0", instr_count4); end
        checks++;
        if (instr_count !== 32'd16) begin failures++; $display("FAIL wrap_32bit got=%0d exp=16", instr_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(1'b1, OP_R, 1'b1);    // IDLE
        repeat (4) cyc(1'b1, OP_R, 1'b1);   // R-type retires
        cyc(1'b1, OP_LW, 1'b1);   // FETCH
        cyc(1'b1, OP_LW, 1'b1);   // DECODE
        cyc(1'b1, OP_LW, 1'b1);   // ADDR
        cyc(1'b1, OP_LW, 1'b0);   // MEM_RD waiting
        checks++;
        if ({state, instr_count} !== {4'd5, 32'd1}) begin
            failures++; $display("FAIL areset_pre got st=%0d cnt=%0d exp st=5 1", state, instr_count);
        end
        #2 rst_n = 1'b0;          // mid-cycle, no clock edge
        #1;
        checks++;
        if ({state, all_outs, instr_count} !== {4'd0, 16'd0, 32'd0}) begin
            failures++; $display("FAIL areset_now got st=%0d outs=%h cnt=%0d exp st=0 outs=0000 cnt=0", state, all_outs, instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Random instruction stream against an instruction-level timeline model.
    task automatic test_random();
        step_t       q[$];
        step_t       s;
        logic [31:0] exp_count;
        logic        need_idle;
        int          cls, fw, mw;
        logic        r;
        logic [6:0]  op;

        do_reset();
        exp_count = 0;
        need_idle = 1'b1;
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 4);
            fw  = $urandom_range(0, 2);
            mw  = $urandom_range(0, 2);
            r   = ($urandom_range(0, 3) != 0);
            case (cls)
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                default: begin
                    op = 7'($urandom);
                    while (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ) op = 7'($urandom);
                end
            endcase
            if (need_idle) q.push_back(mk(4'd0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), 1'b1, op));
            for (int k = 0; k <= fw; k++) q.push_back(mk(4'd1, 0, 0, 1, 0, (k == fw), r, op));
            q.push_back(mk(4'd2, 0, (cls == 4), 0, 0, 1'($urandom_range(0, 1)), r, op));
            case (cls)
                0: begin
                    q.push_back(mk(4'd3, 0, 0, 0, 0, 1'($urandom_range(0, 1)), r, op));
                    q.push_back(mk(4'd7, 1, 0, 0, 0, 1'($urandom_range(0, 1)), r, op));
                end
                1: begin
                    q.push_back(mk(4'd4, 0, 0, 0, 0, 1'($urandom_range(0, 1)), r, op));
                    for (int k = 0; k <= mw; k++) q.push_back(mk(4'd5, 0, 0, 1, 0, (k == mw), r, op));
                    q.push_back(mk(4'd8, 1, 0, 0, 0, 1'($urandom_range(0, 1)), r, op));
                end
                2: begin
                    q.push_back(mk(4'd4, 0, 0, 0, 0, 1'($urandom_range(0, 1)), r, op));
                    for (int k = 0; k <= mw; k++) q.push_back(mk(4'd6, (k == mw), 0, 0, 1, (k == mw), r, op));
                end
                3: q.push_back(mk(4'd9, 1, 0, 0, 0, 1'($urandom_range(0, 1)), r, op));
                default: ;
            endcase
            need_idle = !r;
        end

        while (q.size() > 0) begin
            s = q.pop_front();
            cyc(s.rn, s.op, s.mr);
            checks++;
            if ({state, instr_done, illegal, mem_read, mem_write} !== {s.st, s.done, s.ill, s.mrd, s.mwr}) begin
                failures++; $display("FAIL rand_step got st=%0d done=%b ill=%b mr=%b mw=%b exp st=%0d done=%b ill=%b mr=%b mw=%b",
                                     state, instr_done, illegal, mem_read, mem_write, s.st, s.done, s.ill, s.mrd, s.mwr);
            end
            checks++;
            if (instr_count !== exp_count || instr_count4 !== exp_count[3:0]) begin
                failures++; $display("FAIL rand_count got=%0d/%0d exp=%0d/%0d", instr_count, instr_count4, exp_count, exp_count[3:0]);
            end
            if (s.st == 4'd0) begin
                checks++;
                if (all_outs !== 16'd0) begin failures++; $display("FAIL rand_idle_outs got=%h exp=0000", all_outs); end
            end
            if (s.ret) exp_count++;
        end
        cyc(1'b0, 7'd0, 1'b0);
        checks++;
        if (state !== (need_idle ? 4'd0 : 4'd1) || instr_count !== exp_count) begin
            failures++; $display("FAIL rand_end got st=%0d cnt=%0d exp st=%0d cnt=%0d",
                                 state, instr_count, need_idle ? 0 : 1, exp_count);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_r_type();
        test_lw_waits();
        test_sw_beq();
        test_illegal();
        test_run_drop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
